rename_stage: RTL and testbench
===============================

// Module: rename_stage
// PURPOSE
//  2-wide register rename stage: maps arch regs x0..x31 to phys regs p0..p63 via RAT + FIFO free list.
//  Sits between decode and reservation_station; emits 6-bit physical rs1/rs2/rd plus old rd mapping (for ROB free-on-retire).
//  Retire-side frees return physical regs to the free list.
// PARAMETERS
//  ARCH_REGS  32  architectural registers (x0 hard-wired, never renamed)
//  PHYS_REGS  64  physical registers; free list depth = PHYS_REGS-ARCH_REGS = 32
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   decode group (slots 1,2) valid
//  in_ready       out  1   stage accepts group this cycle
//  rs1_N,rs2_N,rd_N in 5   arch regs, slot N=1,2
//  imm_N          in   32  immediate, slot N
//  alu_op_N       in   3   ALU op, slot N
//  opcode_N       in   7   RV opcode, slot N
//  rs_full        in   1   reservation_station cannot accept; hold outputs
//  prs1_N,prs2_N,prd_N out 6  physical regs, slot N
//  old_prd_N      out  6   previous mapping of rd_N (0 if no write)
//  imm_o_N, alu_op_o_N, opcode_o_N  out 32/3/7  passed through, registered
//  out_valid      out  1   output group valid
//  free_valid_N   in   1   retire frees physical reg, slot N
//  free_preg_N    in   6   physical reg being freed
// BEHAVIOUR
//  - Reset: RAT[i]=i; free list holds p32..p63 (head=0,tail=0,count=32); out_valid=0, all data outputs 0, in_ready=0 during reset.
//  - Writes rd: opcodes 0110011, 0010011, 0000011 with rd!=0. SW(0100011), unknown opcode, rd=0: no alloc, prd=0, old_prd=0.
//  - in_ready = !rs_full && (free_count >= allocs needed by current group). Group is all-or-nothing; never rename only one slot.
//  - Accept (in_valid&&in_ready): pop 0..2 entries from head; outputs registered next cycle (latency 1); out_valid=1.
//  - Not accepted and !rs_full: out_valid=0. rs_full: all outputs, RAT, free list held unchanged.
//  - Intra-group: slot2 rs1/rs2 equal to slot1 rd (writer) -> use slot1 new prd. Same rd both slots -> old_prd_2 = prd_1; RAT ends with prd_2.
//  - Source lookup for rs=0 -> p0 always.
//  - Frees: push at tail, up to 2/cycle, slot1 first. Freed regs allocatable only from next cycle.
//    free_count_next = count - pops + pushes (6-bit, range 0..32).
//  - Same-cycle free + alloc: both occur; in_ready evaluated on pre-update count.
//  - Pointers 5-bit, wrap 31->0 naturally. Push when count=32 or free of p0: dropped (sim $error).
//  - Reset mid-operation: RAT/free list/outputs return to reset state immediately; in-flight group lost.
// CONFIGURATION
//  RENAME_PERF_CNT_EN defined: extra output stall_cycles [31:0], counts cycles with in_valid && !in_ready
//   (saturating at 32'hFFFF_FFFF, reset 0). Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  rename_pkg: ARCH_REGS/PHYS_REGS constants, opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE),
//   typedef preg_t (logic [5:0]), function writes_rd(opcode).
//  Sub-module rename_free_list: circular FIFO, 2 pop / 2 push ports, count output; RAT + bypass logic stay in rename_stage.
// TESTING
//  1. Reset, group add x5,x1,x2 / add x6,x5,x3 -> prd_1=32, prd_2=33, prs1_2=32, old_prd_1=5, old_prd_2=6.
//  2. Both slots rd=x7 -> prd_1=32, prd_2=33, old_prd_2=32; next group reading x7 gets prs1=33.
//  3. sw + rd=0 addi in one group -> no pops, count stays 32, prd_1=prd_2=0.
//  4. Drain to count=1, present 2-writer group -> in_ready=0, out_valid=0; free p5 -> accepted next cycle.
//  5. rs_full=1 for 3 cycles with valid output -> outputs and count held; released -> next group proceeds.
//  6. Assert rst_n=0 mid-stream -> out_valid=0 same cycle; after release RAT identity, count=32 (perf cnt=0 if enabled).

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared constants, opcode encodings and types for the rename stage.
// Revision: 1.0
`default_nettype none

package rename_pkg;

   localparam int ARCH_REGS = 32;
   localparam int PHYS_REGS = 64;
   localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef logic [5:0] preg_t;
   typedef logic [4:0] areg_t;

   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical registers, 2 pops and 2 pushes per cycle.
// Revision: 1.0
`default_nettype none

module rename_free_list
   import rename_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_pop_n,
   output preg_t      o_head0,
   output preg_t      o_head1,
   output logic [5:0] o_count,
   input  logic       i_push_v1,
   input  preg_t      i_push_p1,
   input  logic       i_push_v2,
   input  preg_t      i_push_p2
);

   preg_t      r_mem [FL_DEPTH];
   logic [4:0] r_head;
   logic [4:0] r_tail;
   logic [5:0] r_count;

   logic [5:0] w_after_pop;
   logic       w_ok1;
   logic       w_ok2;
   logic [4:0] w_tail2;
   logic [5:0] w_pushes;

   assign o_head0 = r_mem[r_head];
   assign o_head1 = r_mem[r_head + 5'd1];
   assign o_count = r_count;

   // Capacity is judged after this cycle's pops; p0 is never a legal free.
   assign w_after_pop = r_count - {4'b0, i_pop_n};
   assign w_ok1       = i_push_v1 && (i_push_p1 != '0) && (w_after_pop < 6'(FL_DEPTH));
   assign w_ok2       = i_push_v2 && (i_push_p2 != '0) &&
                        ((w_after_pop + {5'b0, w_ok1}) < 6'(FL_DEPTH));
   assign w_tail2     = r_tail + {4'b0, w_ok1};
   assign w_pushes    = {5'b0, w_ok1} + {5'b0, w_ok2};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_mem[i] <= preg_t'(ARCH_REGS + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 6'(FL_DEPTH);
      end else begin
         if (w_ok1) r_mem[r_tail]  <= i_push_p1;
         if (w_ok2) r_mem[w_tail2] <= i_push_p2;
         r_head  <= r_head + {3'b0, i_pop_n};
         r_tail  <= r_tail + 5'(w_pushes);
         r_count <= w_after_pop + w_pushes;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (i_push_v1 && !w_ok1) $error("free list push dropped: p%0d", i_push_p1);
         if (i_push_v2 && !w_ok2) $error("free list push dropped: p%0d", i_push_p2);
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/rename_stage.sv
// rename_stage: 2-wide RAT rename with FIFO free list; optional stall counter under RENAME_PERF_CNT_EN.
// Revision: 1.0
`default_nettype none

module rename_stage
   import rename_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rs1_1,
   input  logic [4:0]  rs2_1,
   input  logic [4:0]  rd_1,
   input  logic [31:0] imm_1,
   input  logic [2:0]  alu_op_1,
   input  logic [6:0]  opcode_1,
   input  logic [4:0]  rs1_2,
   input  logic [4:0]  rs2_2,
   input  logic [4:0]  rd_2,
   input  logic [31:0] imm_2,
   input  logic [2:0]  alu_op_2,
   input  logic [6:0]  opcode_2,
   input  logic        rs_full,
   output logic [5:0]  prs1_1,
   output logic [5:0]  prs2_1,
   output logic [5:0]  prd_1,
   output logic [5:0]  old_prd_1,
   output logic [5:0]  prs1_2,
   output logic [5:0]  prs2_2,
   output logic [5:0]  prd_2,
   output logic [5:0]  old_prd_2,
   output logic [31:0] imm_o_1,
   output logic [2:0]  alu_op_o_1,
   output logic [6:0]  opcode_o_1,
   output logic [31:0] imm_o_2,
   output logic [2:0]  alu_op_o_2,
   output logic [6:0]  opcode_o_2,
   output logic        out_valid,
   input  logic        free_valid_1,
   input  logic [5:0]  free_preg_1,
   input  logic        free_valid_2,
   input  logic [5:0]  free_preg_2
`ifdef RENAME_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   preg_t      r_rat [ARCH_REGS];

   logic       w_w1;
   logic       w_w2;
   logic [1:0] w_need;
   logic [5:0] w_count;
   logic       w_acc;
   logic [1:0] w_pop_n;
   preg_t      w_head0;
   preg_t      w_head1;
   preg_t      w_new1;
   preg_t      w_new2;
   preg_t      w_prs1_1;
   preg_t      w_prs2_1;
   preg_t      w_prs1_2;
   preg_t      w_prs2_2;
   preg_t      w_old1;
   preg_t      w_old2;

   assign w_w1     = writes_rd(opcode_1) && (rd_1 != '0);
   assign w_w2     = writes_rd(opcode_2) && (rd_2 != '0);
   assign w_need   = {1'b0, w_w1} + {1'b0, w_w2};
   assign in_ready = rst_n && !rs_full && (w_count >= {4'b0, w_need});
   assign w_acc    = in_valid && in_ready;
   assign w_pop_n  = w_acc ? w_need : 2'd0;

   // Slot 2 takes the second free entry only when slot 1 consumed the first.
   assign w_new1 = w_head0;
   assign w_new2 = w_w1 ? w_head1 : w_head0;

   assign w_prs1_1 = (rs1_1 == '0) ? '0 : r_rat[rs1_1];
   assign w_prs2_1 = (rs2_1 == '0) ? '0 : r_rat[rs2_1];
   assign w_prs1_2 = (rs1_2 == '0) ? '0 : (w_w1 && (rs1_2 == rd_1)) ? w_new1 : r_rat[rs1_2];
   assign w_prs2_2 = (rs2_2 == '0) ? '0 : (w_w1 && (rs2_2 == rd_1)) ? w_new1 : r_rat[rs2_2];
   assign w_old1   = w_w1 ? r_rat[rd_1] : '0;
   assign w_old2   = !w_w2 ? '0 : (w_w1 && (rd_1 == rd_2)) ? w_new1 : r_rat[rd_2];

   rename_free_list u_free_list (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pop_n   (w_pop_n),
      .o_head0   (w_head0),
      .o_head1   (w_head1),
      .o_count   (w_count),
      .i_push_v1 (free_valid_1),
      .i_push_p1 (free_preg_1),
      .i_push_v2 (free_valid_2),
      .i_push_p2 (free_preg_2)
   );

   // Slot 2 is written last so a shared rd ends mapped to slot 2's register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_rat[i] <= preg_t'(i);
         end
      end else if (w_acc) begin
         if (w_w1) r_rat[rd_1] <= w_new1;
         if (w_w2) r_rat[rd_2] <= w_new2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         prs1_1     <= '0;
         prs2_1     <= '0;
         prd_1      <= '0;
         old_prd_1  <= '0;
         prs1_2     <= '0;
         prs2_2     <= '0;
         prd_2      <= '0;
         old_prd_2  <= '0;
         imm_o_1    <= '0;
         alu_op_o_1 <= '0;
         opcode_o_1 <= '0;
         imm_o_2    <= '0;
         alu_op_o_2 <= '0;
         opcode_o_2 <= '0;
      end else if (!rs_full) begin
         out_valid <= w_acc;
         if (w_acc) begin
            prs1_1     <= w_prs1_1;
            prs2_1     <= w_prs2_1;
            prd_1      <= w_w1 ? w_new1 : '0;
            old_prd_1  <= w_old1;
            prs1_2     <= w_prs1_2;
            prs2_2     <= w_prs2_2;
            prd_2      <= w_w2 ? w_new2 : '0;
            old_prd_2  <= w_old2;
            imm_o_1    <= imm_1;
            alu_op_o_1 <= alu_op_1;
            opcode_o_1 <= opcode_1;
            imm_o_2    <= imm_2;
            alu_op_o_2 <= alu_op_2;
            opcode_o_2 <= opcode_2;
         end
      end
   end

`ifdef RENAME_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rename_stage.sv
// tb_rename_stage: scoreboard bench for rename_stage against a sequential RAT/free-list model.
// Revision: 1.0
`default_nettype none

module tb_rename_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  rs1_1 = '0, rs2_1 = '0, rd_1 = '0, rs1_2 = '0, rs2_2 = '0, rd_2 = '0;
   logic [31:0] imm_1 = '0, imm_2 = '0;
   logic [2:0]  alu_op_1 = '0, alu_op_2 = '0;
   logic [6:0]  opcode_1 = '0, opcode_2 = '0;
   logic        rs_full = 1'b0;
   logic [5:0]  prs1_1, prs2_1, prd_1, old_prd_1, prs1_2, prs2_2, prd_2, old_prd_2;
   logic [31:0] imm_o_1, imm_o_2;
   logic [2:0]  alu_op_o_1, alu_op_o_2;
   logic [6:0]  opcode_o_1, opcode_o_2;
   logic        out_valid;
   logic        free_valid_1 = 1'b0, free_valid_2 = 1'b0;
   logic [5:0]  free_preg_1 = '0, free_preg_2 = '0;
`ifdef RENAME_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   rename_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .imm_1(imm_1), .alu_op_1(alu_op_1), .opcode_1(opcode_1),
      .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2), .imm_2(imm_2), .alu_op_2(alu_op_2), .opcode_2(opcode_2),
      .rs_full(rs_full),
      .prs1_1(prs1_1), .prs2_1(prs2_1), .prd_1(prd_1), .old_prd_1(old_prd_1),
      .prs1_2(prs1_2), .prs2_2(prs2_2), .prd_2(prd_2), .old_prd_2(old_prd_2),
      .imm_o_1(imm_o_1), .alu_op_o_1(alu_op_o_1), .opcode_o_1(opcode_o_1),
      .imm_o_2(imm_o_2), .alu_op_o_2(alu_op_o_2), .opcode_o_2(opcode_o_2),
      .out_valid(out_valid),
      .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
      .free_valid_2(free_valid_2), .free_preg_2(free_preg_2)
`ifdef RENAME_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      logic [5:0]  prs1_1, prs2_1, prd_1, old_1, prs1_2, prs2_2, prd_2, old_2;
      logic [31:0] imm_1, imm_2;
      logic [2:0]  alu_1, alu_2;
      logic [6:0]  op_1, op_2;
   } exp_t;

   exp_t sb[$];
   int   m_rat[32];
   int   m_fl[$];
   int   m_stall;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int m_writes(input logic [6:0] op, input logic [4:0] rd);
      return ((op == 7'h33 || op == 7'h13 || op == 7'h03) && rd != 5'd0) ? 1 : 0;
   endfunction

   function automatic int m_src(input logic [4:0] rs);
      return (rs == 5'd0) ? 0 : m_rat[rs];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rat[i] = i;
      m_fl.delete();
      for (int i = 32; i < 64; i++) m_fl.push_back(i);
      sb.delete();
      m_stall = 0;
   endtask

   // Renames slot 1 completely before slot 2, so intra-group forwarding falls out naturally.
   task automatic model_accept();
      exp_t e;
      e.prs1_1 = 6'(m_src(rs1_1));
      e.prs2_1 = 6'(m_src(rs2_1));
      e.prd_1 = '0; e.old_1 = '0;
      if (m_writes(opcode_1, rd_1) != 0) begin
         e.old_1 = 6'(m_rat[rd_1]);
         e.prd_1 = 6'(m_fl.pop_front());
         m_rat[rd_1] = int'(e.prd_1);
      end
      e.prs1_2 = 6'(m_src(rs1_2));
      e.prs2_2 = 6'(m_src(rs2_2));
      e.prd_2 = '0; e.old_2 = '0;
      if (m_writes(opcode_2, rd_2) != 0) begin
         e.old_2 = 6'(m_rat[rd_2]);
         e.prd_2 = 6'(m_fl.pop_front());
         m_rat[rd_2] = int'(e.prd_2);
      end
      e.imm_1 = imm_1; e.imm_2 = imm_2;
      e.alu_1 = alu_op_1; e.alu_2 = alu_op_2;
      e.op_1 = opcode_1; e.op_2 = opcode_2;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      bit   rdy;
      int   need;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("out_valid", out_valid, 1);
         check("prs1_1", prs1_1, e.prs1_1);  check("prs2_1", prs2_1, e.prs2_1);
         check("prd_1", prd_1, e.prd_1);     check("old_prd_1", old_prd_1, e.old_1);
         check("prs1_2", prs1_2, e.prs1_2);  check("prs2_2", prs2_2, e.prs2_2);
         check("prd_2", prd_2, e.prd_2);     check("old_prd_2", old_prd_2, e.old_2);
         check("imm_o_1", imm_o_1, e.imm_1); check("imm_o_2", imm_o_2, e.imm_2);
         check("alu_o_1", alu_op_o_1, e.alu_1); check("alu_o_2", alu_op_o_2, e.alu_2);
         check("op_o_1", opcode_o_1, e.op_1);   check("op_o_2", opcode_o_2, e.op_2);
      end
      need = m_writes(opcode_1, rd_1) + m_writes(opcode_2, rd_2);
      rdy  = rst_n && !rs_full && (m_fl.size() >= need);
      check("in_ready", in_ready, rdy);
      if (in_valid && rdy) model_accept();
      if (rst_n && in_valid && !rdy) m_stall++;
      if (rst_n && free_valid_1 && free_preg_1 != 0 && m_fl.size() < 32) m_fl.push_back(free_preg_1);
      if (rst_n && free_valid_2 && free_preg_2 != 0 && m_fl.size() < 32) m_fl.push_back(free_preg_2);
      @(posedge clk);
      #1;
      free_valid_1 = 1'b0;
      free_valid_2 = 1'b0;
   endtask

   task automatic slot1(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      opcode_1 = op; rd_1 = rd; rs1_1 = a; rs2_1 = b;
      imm_1 = $urandom; alu_op_1 = 3'($urandom);
   endtask

   task automatic slot2(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      opcode_2 = op; rd_2 = rd; rs1_2 = a; rs2_2 = b;
      imm_2 = $urandom; alu_op_2 = 3'($urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; rs_full = 1'b0; free_valid_1 = 1'b0; free_valid_2 = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      model_reset();
      @(negedge clk);
      check("rst_prd_1", prd_1, 0);
      check("rst_old_prd_2", old_prd_2, 0);
      check("rst_imm_o_1", imm_o_1, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`ifdef RENAME_PERF_CNT_EN
      check("rst_stall_cycles", stall_cycles, 0);
`endif
   endtask

   localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_L = 7'b0000011, T_S = 7'b0100011;

   initial begin
      #2;
      do_reset();

      // Dependent pair: slot 2 reads slot 1's destination.
      slot1(T_R, 5, 1, 2); slot2(T_R, 6, 5, 3); in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      check("t1_prd_1", prd_1, 32); check("t1_prd_2", prd_2, 33); check("t1_prs1_2", prs1_2, 32);
      check("t1_old_1", old_prd_1, 5); check("t1_old_2", old_prd_2, 6);
      cycle();
      check("t1_idle_valid", out_valid, 0);

      // Same destination in both slots.
      do_reset();
      slot1(T_I, 7, 0, 0); slot2(T_I, 7, 0, 0); in_valid = 1'b1;
      cycle();
      check("t2_prd_1", prd_1, 32); check("t2_prd_2", prd_2, 33); check("t2_old_2", old_prd_2, 32);
      slot1(T_R, 8, 7, 0); slot2(T_S, 0, 7, 8);
      cycle();
      in_valid = 1'b0;
      check("t2_prs1_x7", prs1_1, 33); check("t2_prs2_x0", prs2_1, 0); check("t2_prs2_2_byp", prs2_2, 34);
      cycle();

      // No-writer group leaves the free list untouched.
      do_reset();
      slot1(T_S, 5, 2, 3); slot2(T_I, 0, 4, 0); in_valid = 1'b1;
      cycle();
      check("t3_prd_1", prd_1, 0); check("t3_prd_2", prd_2, 0);
      slot1(T_L, 1, 2, 0); slot2(T_S, 0, 1, 1);
      cycle();
      in_valid = 1'b0;
      check("t3_next_prd", prd_1, 32); check("t3_fwd_store", prs1_2, 32);
      cycle();

      // Drain to one free entry, then starve a two-writer group until a free arrives.
      do_reset();
      in_valid = 1'b1;
      for (int k = 0; k < 15; k++) begin
         slot1(T_I, 5'(2 * k + 1), 5'(k), 0); slot2(T_I, 5'(2 * k + 2), 5'(2 * k + 1), 0);
         cycle();
      end
      slot1(T_I, 31, 30, 0); slot2(T_S, 0, 31, 30);
      cycle();
      slot1(T_R, 5, 1, 2); slot2(T_R, 6, 5, 3);
      free_valid_1 = 1'b1; free_preg_1 = 6'd5;
      cycle();
      check("t4_starved_valid", out_valid, 0);
      cycle();
      in_valid = 1'b0;
      check("t4_prd_1", prd_1, 63); check("t4_prd_2", prd_2, 5);
      cycle();
`ifdef RENAME_PERF_CNT_EN
      check("t4_stall_cycles", stall_cycles, 32'(m_stall));
`endif

      // Back-pressure holds outputs and allocation.
      do_reset();
      slot1(T_R, 1, 2, 3); slot2(T_R, 2, 1, 0); in_valid = 1'b1;
      cycle();
      rs_full = 1'b1;
      slot1(T_R, 3, 1, 2); slot2(T_S, 0, 3, 3);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t5_hold_valid", out_valid, 1); check("t5_hold_prd_1", prd_1, 32);
         check("t5_hold_prd_2", prd_2, 33); check("t5_hold_prs1_2", prs1_2, 32);
      end
      rs_full = 1'b0;
      cycle();
      in_valid = 1'b0;
      check("t5_rel_prd_1", prd_1, 34); check("t5_rel_prs1_1", prs1_1, 32); check("t5_rel_prs2_1", prs2_1, 33);
      cycle();

      // Randomised traffic with frees and back-pressure.
      for (int k = 0; k < 80; k++) begin
         logic [6:0] ops [5];
         ops[0] = T_R; ops[1] = T_I; ops[2] = T_L; ops[3] = T_S; ops[4] = 7'b0110111;
         slot1(ops[$urandom_range(4)], 5'($urandom), 5'($urandom), 5'($urandom));
         slot2(ops[$urandom_range(4)], 5'($urandom), 5'($urandom), 5'($urandom));
         in_valid = ($urandom_range(3) != 0);
         rs_full  = ($urandom_range(7) == 0);
         if (m_fl.size() <= 28) begin
            free_valid_1 = $urandom_range(1); free_preg_1 = 6'($urandom_range(63, 1));
            free_valid_2 = $urandom_range(1); free_preg_2 = 6'($urandom_range(63, 1));
         end
         cycle();
      end
      in_valid = 1'b0; rs_full = 1'b0;
      cycle();

      // Reset in the middle of a live output.
      slot1(T_R, 9, 1, 2); slot2(T_R, 10, 9, 9); in_valid = 1'b1;
      cycle();
      do_reset();
      slot1(T_R, 3, 1, 2); slot2(T_S, 0, 4, 5); in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      check("t6_prs1_ident", prs1_1, 1); check("t6_prs2_2_ident", prs2_2, 5); check("t6_prd_1", prd_1, 32);
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
